sram16_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port SRAM16K macro (wrapped by sram16_top) between requester A and requester B. It accepts one access per cycle, using a round-robin policy with an optional lock for back-to-back bursts. It drives the macro's cs/addr/wdata/wen and routes read data back to whichever requester issued the read, with a valid strobe. It sits directly between the two bus masters and sram16_top.

---
 rtl/sram16_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram16_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram16_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port SRAM16K macro.
// Supports locked bursts (bounded by MAX_LOCK grants) and routes read data back to the issuer.
module sram16_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_lock,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_wen,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_lock,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_wen,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                sram_cs,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wen,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [1:0]          dbg_state
);

  // Handshake: a transfer happens in any cycle with X_req=1 and X_gnt=1; the requester
  // holds req/addr/wdata/wen stable until granted. gnt is combinational from req, state and rr_ptr.

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  // lock_cnt already counts the grant being made, so the MAX_LOCK-th grant ends the burst.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LOCK - 1);
  localparam logic             CAN_LOCK = (MAX_LOCK > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              rr_ptr, rr_nxt;      // 0 = A has priority, 1 = B
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              grant_a, grant_b;
  logic              own_is_b, own_req, own_lock;
  logic              is_read;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_own;            // 1 = read belongs to B
  logic              head_vld, head_own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    lock_cnt_nxt = lock_cnt;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    own_is_b     = (state == OWN_B);
    own_req      = own_is_b ? b_req  : a_req;
    own_lock     = own_is_b ? b_lock : a_lock;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          grant_a = ~rr_ptr;
          grant_b = rr_ptr;
          rr_nxt  = ~rr_ptr;
        end else begin
          grant_a = a_req;
          grant_b = b_req;
        end
        if (CAN_LOCK && ((grant_a && a_lock) || (grant_b && b_lock))) begin
          state_nxt    = grant_a ? OWN_A : OWN_B;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      OWN_A, OWN_B: begin
        grant_a = !own_is_b && a_req;
        grant_b = own_is_b && b_req;
        if (own_req) begin
          if (own_lock && (lock_cnt != LAST_CNT)) begin
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end else begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
            rr_nxt       = ~own_is_b;
          end
        end else if (!own_lock) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Reset must silence the grants immediately even though they are combinational from req.
  assign a_gnt = grant_a & rst_n;
  assign b_gnt = grant_b & rst_n;

  assign sram_cs    = a_gnt | b_gnt;
  assign sram_addr  = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
  assign sram_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);
  assign sram_wen   = a_gnt ? a_wen   : (b_gnt ? b_wen   : '0);
  assign is_read    = sram_cs && (sram_wen == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= is_read;
      pipe_own[0] <= b_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign head_vld = pipe_vld[RD_LAT-1];
  assign head_own = pipe_own[RD_LAT-1];

  assign a_rvalid = head_vld & ~head_own;
  assign b_rvalid = head_vld & head_own;
  assign a_rdata  = a_rvalid ? sram_rdata : '0;
  assign b_rdata  = b_rvalid ? sram_rdata : '0;

  assign dbg_state = state;

  // BE_W only documents the lane count; keep it referenced for readers of the port list.
  logic [BE_W-1:0] unused_be;
  assign unused_be = '0;

endmodule

// File: tb/tb_sram16_arbiter.sv
// Directed bench for sram16_arbiter: SRAM macro stub, rule-level reference model with an
// every-cycle compare process, and hand-computed literal checks for each scenario.
module tb_sram16_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int MAX_LOCK = 15;

  logic               clk, rst_n;
  logic               a_req, a_lock, b_req, b_lock;
  logic [ADDR_W-1:0]  a_addr, b_addr, sram_addr;
  logic [DATA_W-1:0]  a_wdata, b_wdata, a_rdata, b_rdata, sram_wdata, sram_rdata;
  logic [3:0]         a_wen, b_wen, sram_wen;
  logic               a_gnt, b_gnt, a_rvalid, b_rvalid, sram_cs;
  logic [1:0]         dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sram16_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata), .a_wen(a_wen),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata), .b_wen(b_wen),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wen(sram_wen),
    .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- SRAM macro stub ----------------
  logic [DATA_W-1:0] mem [0:4095];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  initial for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  assign sram_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_cs && sram_wen == 4'h0) rd_pipe[0] <= mem[sram_addr];
    if (sram_cs && sram_wen != 4'h0)
      for (int k = 0; k < 4; k++)
        if (sram_wen[k]) mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ownership as "who owns / grants so far / who is next", reads as a queue.
  logic [DATA_W-1:0] shadow [0:4095];
  initial for (int i = 0; i < 4096; i++) shadow[i] = '0;
  logic [DATA_W-1:0] exp_q[$];
  int due_q[$];
  int own_q[$];
  int owner = -1;
  int burst = 0;
  int rr    = 0;

  always @(negedge clk) begin
    int g;
    logic lk, olk;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_ard, e_brd;
    logic [3:0] e_wen;
    logic e_arv, e_brv;
    cyc++;
    g = -1; e_addr = '0; e_wdata = '0; e_wen = '0;
    e_arv = 1'b0; e_brv = 1'b0; e_ard = '0; e_brd = '0;
    if (!rst_n) begin
      owner = -1; burst = 0; rr = 0;
      exp_q.delete(); due_q.delete(); own_q.delete();
    end else begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (own_q[0] == 0) begin e_arv = 1'b1; e_ard = exp_q[0]; end
        else               begin e_brv = 1'b1; e_brd = exp_q[0]; end
        void'(due_q.pop_front()); void'(own_q.pop_front()); void'(exp_q.pop_front());
      end
      if (owner < 0) begin
        if (a_req && b_req) g = rr;
        else if (a_req)     g = 0;
        else if (b_req)     g = 1;
      end else if ((owner == 0) ? a_req : b_req) begin
        g = owner;
      end
      if (g >= 0) begin
        e_addr  = (g == 1) ? b_addr  : a_addr;
        e_wdata = (g == 1) ? b_wdata : a_wdata;
        e_wen   = (g == 1) ? b_wen   : a_wen;
        if (e_wen == 4'h0) begin
          due_q.push_back(cyc + RD_LAT); own_q.push_back(g); exp_q.push_back(shadow[e_addr]);
        end else begin
          for (int k = 0; k < 4; k++)
            if (e_wen[k]) shadow[e_addr][8*k +: 8] = e_wdata[8*k +: 8];
        end
      end
      lk  = (g == 1) ? b_lock : a_lock;
      olk = (owner == 1) ? b_lock : a_lock;
      if (owner < 0) begin
        if (a_req && b_req) rr = 1 - g;
        if (g >= 0 && lk && MAX_LOCK > 1) begin owner = g; burst = 1; end
      end else if (g >= 0) begin
        if (lk && burst + 1 < MAX_LOCK) burst++;
        else begin owner = -1; burst = 0; rr = 1 - g; end
      end else if (!olk) begin
        owner = -1; burst = 0;
      end
    end
    chk("m_a_gnt",    a_gnt,      g == 0);
    chk("m_b_gnt",    b_gnt,      g == 1);
    chk("m_cs",       sram_cs,    g >= 0);
    chk("m_addr",     sram_addr,  e_addr);
    chk("m_wdata",    sram_wdata, e_wdata);
    chk("m_wen",      sram_wen,   e_wen);
    chk("m_a_rvalid", a_rvalid,   e_arv);
    chk("m_a_rdata",  a_rdata,    e_ard);
    chk("m_b_rvalid", b_rvalid,   e_brv);
    chk("m_b_rdata",  b_rdata,    e_brd);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic ar, input logic al, input logic [11:0] aa,
                      input logic [31:0] ad, input logic [3:0] aw,
                      input logic br, input logic bl, input logic [11:0] ba,
                      input logic [31:0] bd, input logic [3:0] bw);
    @(posedge clk); #1;
    a_req = ar; a_lock = al; a_addr = aa; a_wdata = ad; a_wen = aw;
    b_req = br; b_lock = bl; b_addr = ba; b_wdata = bd; b_wen = bw;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_lock = 1'b0; a_addr = 12'h005; a_wdata = 32'h1; a_wen = 4'h0;
    b_req = 1'b1; b_lock = 1'b0; b_addr = 12'h006; b_wdata = 32'h2; b_wen = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_cs", sram_cs, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;

    // Single write then read by A.
    step(1'b1, 1'b0, 12'h005, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("p1_wr_gnt", a_gnt, 1'b1);
    step(1'b1, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("p1_rd_gnt", a_gnt, 1'b1);
    repeat (RD_LAT - 1) idle();
    idle();
    chk("p1_rvalid", a_rvalid, 1'b1);
    chk("p1_rdata", a_rdata, 32'hDEADBEEF);
    chk("p1_b_rvalid", b_rvalid, 1'b0);
    idle();
    chk("p1_rvalid_once", a_rvalid, 1'b0);

    // Contention without lock: strict alternation starting with A.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 12'h010 + 12'((i + 1) / 2), 32'h0, 4'h0,
           1'b1, 1'b0, 12'h020 + 12'(i / 2), 32'hB000_0000 + 32'(i), 4'hF);
      chk("p2_a_gnt", a_gnt, (i % 2) == 0);
      chk("p2_b_gnt", b_gnt, (i % 2) == 1);
      chk("p2_addr", sram_addr, ((i % 2) == 0) ? 12'h010 + 12'(i / 2) : 12'h020 + 12'(i / 2));
    end
    idle();

    // Byte enables: full write by A, partial write by B, read back by B.
    step(1'b1, 1'b0, 12'h0FF, 32'h11223344, 4'hF, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0, 12'h0FF, 32'hAABBCCDD, 4'b0101);
    chk("p3_b_wr_wen", sram_wen, 4'b0101);
    step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0, 12'h0FF, 32'h0, 4'h0);
    repeat (RD_LAT - 1) idle();
    idle();
    chk("p3_b_rvalid", b_rvalid, 1'b1);
    chk("p3_b_rdata", b_rdata, 32'h11BB33DD);
    chk("p3_a_rvalid", a_rvalid, 1'b0);

    // Lock burst: A locked with B waiting; lock broken after 15 grants.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 12'h020 + 12'(i - 1), 32'h0, 4'h0,
           1'b1, 1'b0, 12'h300, 32'hCAFE0000, 4'hF);
      chk("p4_a_gnt", a_gnt, i <= 15);
      chk("p4_b_gnt", b_gnt, i == 16);
      if (i == 2)  chk("p4_state_own", dbg_state, 2'd1);
      if (i == 16) chk("p4_state_idle", dbg_state, 2'd0);
    end

    // Lock release by A, then B-locked ownership held through an empty cycle.
    step(1'b1, 1'b1, 12'h02F, 32'h0, 4'h0, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0);
    chk("p5_c1_a_gnt", a_gnt, 1'b1);
    step(1'b1, 1'b1, 12'h030, 32'h0, 4'h0, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0);
    chk("p5_c2_b_gnt", b_gnt, 1'b0);
    step(1'b1, 1'b0, 12'h031, 32'h0, 4'h0, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0);
    chk("p5_c3_a_gnt", a_gnt, 1'b1);
    step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0);
    chk("p5_c4_b_gnt", b_gnt, 1'b1);
    chk("p5_c4_state", dbg_state, 2'd0);
    step(1'b1, 1'b0, 12'h050, 32'h0, 4'h0, 1'b1, 1'b1, 12'h041, 32'h12345678, 4'hF);
    chk("p5_c5_b_gnt", b_gnt, 1'b1);
    step(1'b1, 1'b0, 12'h050, 32'h0, 4'h0, 1'b0, 1'b1, 12'h0, 32'h0, 4'h0);
    chk("p5_c6_a_wait", a_gnt, 1'b0);
    step(1'b1, 1'b0, 12'h050, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("p5_c7_a_wait", a_gnt, 1'b0);
    step(1'b1, 1'b0, 12'h050, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("p5_c8_a_gnt", a_gnt, 1'b1);
    step(1'b1, 1'b0, 12'h041, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    repeat (RD_LAT - 1) idle();
    idle();
    chk("p5_rdata", a_rdata, 32'h12345678);

    // Reset one cycle after a read grant: read dropped, A first after release.
    step(1'b1, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("p6_rd_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; b_req = 1'b1; b_addr = 12'h041;
    @(negedge clk);
    chk("p6_rvalid", a_rvalid, 1'b0);
    chk("p6_rdata", a_rdata, 32'h0);
    chk("p6_gnt", {a_gnt, b_gnt}, 2'b00);
    chk("p6_sram_addr", sram_addr, 12'h0);
    @(negedge clk);
    chk("p6_cs", sram_cs, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("p6_first_a", a_gnt, 1'b1);
    chk("p6_first_b", b_gnt, 1'b0);
    step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0, 12'h041, 32'h0, 4'h0);
    chk("p6_then_b", b_gnt, 1'b1);
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
